// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl
// Bit-serial sequencer that drives a 1-bit ALU (alu1bit) one bit per clock,
// LSB first. The carry between bits is held in a flop.
//
// Ports
//   clk, rst           clock (rising edge) and synchronous active-high reset
//   start              operation request; only sampled in IDLE or DONE
//   a_in, b_in, op_in  operands and op (00 NOR, 01 XOR, 10 ADD, 11 SUB A-B)
//   busy               high while bits are being processed (RUN)
//   done               one-cycle pulse; result and flags are valid
//   result             N-bit result, held until the next operation completes
//   cout_out, ovf      final carry / signed overflow (arithmetic ops only)
//   zero               result == 0
//   alu_a, alu_b       operand bits to the ALU (LSBs of the shift registers)
//   alu_cin, alu_op    carry-in and op to the ALU (both from flops)
//   alu_s, alu_cout    ALU outputs, sampled at the next clock edge
`timescale 1ns/1ps
module alu_serial_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic [1:0]   op_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         cout_out,
    output logic         ovf,
    output logic         zero,
    output logic         alu_a,
    output logic         alu_b,
    output logic         alu_cin,
    output logic [1:0]   alu_op,
    input  logic         alu_s,
    input  logic         alu_cout
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t        state_reg;
    logic [N-1:0]  a_sh_reg;
    logic [N-1:0]  b_sh_reg;
    logic [N-1:0]  res_sh_reg;
    logic [CW-1:0] cnt_reg;
    logic          carry_reg;
    logic [N-1:0]  res_next;

    // The ALU output for the current bit enters at the MSB; after N bits the
    // first (LSB) result bit has shifted down to position 0.
    assign res_next = {alu_s, res_sh_reg[N-1:1]};

    assign alu_a   = a_sh_reg[0];
    assign alu_b   = b_sh_reg[0];
    assign alu_cin = carry_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            alu_op     <= 2'b00;
            result     <= '0;
            cout_out   <= 1'b0;
            ovf        <= 1'b0;
            zero       <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh_reg  <= a_in;
                        b_sh_reg  <= b_in;
                        alu_op    <= op_in;
                        cnt_reg   <= '0;
                        // SUB is A + ~B + 1: the +1 enters as the first carry-in.
                        // The ALU inverts B itself for op 11.
                        carry_reg <= (op_in == 2'b11);
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    res_sh_reg <= res_next;
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    carry_reg  <= alu_op[1] & alu_cout;
                    if (cnt_reg == CNT_LAST) begin
                        result    <= res_next;
                        cout_out  <= alu_op[1] & alu_cout;
                        // carry_reg is the carry into the MSB; alu_cout is the carry out of it.
                        ovf       <= alu_op[1] & (carry_reg ^ alu_cout);
                        zero      <= (res_next == '0);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
`timescale 1ns/1ps
module tb_alu_serial_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [1:0] op_in;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       cout_out;
    logic       ovf;
    logic       zero;
    logic       alu_a;
    logic       alu_b;
    logic       alu_cin;
    logic [1:0] alu_op;
    logic       alu_s;
    logic       alu_cout;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] res;
        logic       cout;
        logic       ovf;
        logic       zero;
    } exp_t;

    exp_t sb[$];

    alu_serial_ctrl #(.N(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .op_in(op_in),
        .busy(busy), .done(done), .result(result), .cout_out(cout_out), .ovf(ovf),
        .zero(zero), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
        .alu_s(alu_s), .alu_cout(alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-bit ALU model, zero-delay and delayed variants
    logic s_zero, c_zero, s_dly, c_dly, use_dly;
    logic nb;
    always_comb begin
        s_zero = 1'b0;
        c_zero = 1'b0;
        nb     = ~alu_b;
        case (alu_op)
            2'b00: s_zero = ~(alu_a | alu_b);
            2'b01: s_zero = alu_a ^ alu_b;
            2'b10: {c_zero, s_zero} = {1'b0, alu_a} + {1'b0, alu_b} + {1'b0, alu_cin};
            default: {c_zero, s_zero} = {1'b0, alu_a} + {1'b0, nb} + {1'b0, alu_cin};
        endcase
    end
    assign #3 s_dly = s_zero;
    assign #3 c_dly = c_zero;
    assign alu_s    = use_dly ? s_dly : s_zero;
    assign alu_cout = use_dly ? c_dly : c_zero;

    // Whole-word reference for the expected outcome
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        exp_t e;
        logic [8:0] full;
        e = '0;
        case (op)
            2'b00: e.res = ~(a | b);
            2'b01: e.res = a ^ b;
            2'b10: begin
                full   = {1'b0, a} + {1'b0, b};
                e.res  = full[7:0];
                e.cout = full[8];
                e.ovf  = (a[7] == b[7]) && (e.res[7] != a[7]);
            end
            default: begin
                full   = {1'b0, a} + {1'b0, ~b} + 9'd1;
                e.res  = full[7:0];
                e.cout = full[8];
                e.ovf  = (a[7] != b[7]) && (e.res[7] != a[7]);
            end
        endcase
        e.zero = (e.res == 8'h00);
        return e;
    endfunction

    // Issue one operation, push its expectation, wait (bounded) for done.
    // lat = cycles from the accepting edge to done, -1 on timeout.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op, output int lat);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        op_in = op;
        start = 1'b1;
        sb.push_back(model(a, b, op));
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        $display("op=%b a=%h b=%h -> result=%h cout=%b ovf=%b zero=%b lat=%0d",
                 op, a, b, result, cout_out, ovf, zero, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; op_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, result, cout_out, ovf, zero} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b result=%h c=%b v=%b z=%b, required all 0",
                     busy, done, result, cout_out, ovf, zero);
        end
        checks++;
        if ({alu_a, alu_b, alu_cin, alu_op} !== 5'd0) begin
            errors++;
            $display("FAIL reset_alu_drive: a=%b b=%b cin=%b op=%b, required all 0",
                     alu_a, alu_b, alu_cin, alu_op);
        end
        rst = 1'b0;
        $display("reset applied");
    endtask

    task automatic test_arith(input string tag);
        logic [7:0] a, b;
        logic [1:0] o;
        int lat;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin a = 8'h3A; b = 8'h25; o = 2'b10; end
                1: begin a = 8'hFF; b = 8'h01; o = 2'b10; end
                2: begin a = 8'h7F; b = 8'h01; o = 2'b10; end
                3: begin a = 8'h10; b = 8'h01; o = 2'b11; end
                default: begin a = 8'h80; b = 8'h01; o = 2'b11; end
            endcase
            do_op(a, b, o, lat);
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL %s_latency[%0d]: got %0d cycles, required 8", tag, i, lat);
            end
            e = sb.pop_front();
            checks++;
            if ({result, cout_out, ovf, zero} !== {e.res, e.cout, e.ovf, e.zero}) begin
                errors++;
                $display("FAIL %s_result[%0d]: got %h c=%b v=%b z=%b, required %h c=%b v=%b z=%b",
                         tag, i, result, cout_out, ovf, zero, e.res, e.cout, e.ovf, e.zero);
            end
        end
    endtask

    task automatic test_logic(input string tag);
        logic [7:0] a, b;
        logic [1:0] o;
        int lat;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin a = 8'hA5; b = 8'h0F; o = 2'b01; end
                1: begin a = 8'h0F; b = 8'hF0; o = 2'b00; end
                default: begin a = 8'h12; b = 8'h34; o = 2'b00; end
            endcase
            do_op(a, b, o, lat);
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL %s_latency[%0d]: got %0d cycles, required 8", tag, i, lat);
            end
            e = sb.pop_front();
            checks++;
            if ({result, cout_out, ovf, zero} !== {e.res, e.cout, e.ovf, e.zero}) begin
                errors++;
                $display("FAIL %s_result[%0d]: got %h c=%b v=%b z=%b, required %h c=%b v=%b z=%b",
                         tag, i, result, cout_out, ovf, zero, e.res, e.cout, e.ovf, e.zero);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        exp_t e;
        @(negedge clk);
        a_in = 8'h21; b_in = 8'h13; op_in = 2'b10; start = 1'b1;
        sb.push_back(model(8'h21, 8'h13, 2'b10));
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) begin
                // sampled at RUN edge 3 with different operands; must be ignored
                start = 1'b1; a_in = 8'hFF; b_in = 8'hFF; op_in = 2'b11;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        $display("ignore_start: result=%h lat=%0d", result, lat);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL ignore_latency: got %0d cycles, required 8", lat);
        end
        e = sb.pop_front();
        checks++;
        if ({result, cout_out, ovf, zero} !== {e.res, e.cout, e.ovf, e.zero}) begin
            errors++;
            $display("FAIL ignore_result: got %h c=%b v=%b z=%b, required %h c=%b v=%b z=%b",
                     result, cout_out, ovf, zero, e.res, e.cout, e.ovf, e.zero);
        end
        // the extra start must not have launched another operation
        checks++;
        @(posedge clk);
        #1;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_relaunch: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        @(negedge clk);
        a_in = 8'h44; b_in = 8'h11; op_in = 2'b10; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        $display("reset_mid_run: busy=%b done=%b result=%h", busy, done, result);
        checks++;
        if ({busy, done, result, cout_out, ovf, zero, alu_cin, alu_op} !== 16'd0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b result=%h c=%b v=%b z=%b cin=%b op=%b, required all 0",
                     busy, done, result, cout_out, ovf, zero, alu_cin, alu_op);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midrun_idle: busy/done seen %0d cycles after reset, required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        exp_t e;
        @(negedge clk);
        a_in = 8'h11; b_in = 8'h22; op_in = 2'b10; start = 1'b1;
        sb.push_back(model(8'h11, 8'h22, 2'b10));
        @(posedge clk);
        #1;
        t1 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                t1 = i;
                break;
            end
        end
        // new operands accepted at the next edge while start stays high
        a_in = 8'h40; b_in = 8'h0C; op_in = 2'b10;
        sb.push_back(model(8'h40, 8'h0C, 2'b10));
        $display("b2b first: result=%h lat=%0d", result, t1);
        checks++;
        if (t1 !== 8) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d, required 8", t1);
        end
        e = sb.pop_front();
        checks++;
        if ({result, cout_out, ovf, zero} !== {e.res, e.cout, e.ovf, e.zero}) begin
            errors++;
            $display("FAIL b2b_first_result: got %h c=%b v=%b z=%b, required %h c=%b v=%b z=%b",
                     result, cout_out, ovf, zero, e.res, e.cout, e.ovf, e.zero);
        end
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_immediate_run: done=%b busy=%b, required 0 1", done, busy);
        end
        t2 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                t2 = i + 1;
                break;
            end
        end
        $display("b2b second: result=%h gap=%0d", result, t2);
        checks++;
        if (t2 !== 9) begin
            errors++;
            $display("FAIL b2b_done_spacing: got %0d cycles, required 9", t2);
        end
        e = sb.pop_front();
        checks++;
        if ({result, cout_out, ovf, zero} !== {e.res, e.cout, e.ovf, e.zero}) begin
            errors++;
            $display("FAIL b2b_second_result: got %h c=%b v=%b z=%b, required %h c=%b v=%b z=%b",
                     result, cout_out, ovf, zero, e.res, e.cout, e.ovf, e.zero);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_width: done=%b one cycle later, required 0", done);
        end
    endtask

    initial begin
        use_dly = 1'b0;
        test_reset();
        test_arith("arith");
        test_logic("logic");
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        use_dly = 1'b1;
        test_arith("arith_dly");
        test_logic("logic_dly");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
